// File: rtl/branch_pc_unit.sv
// Branch resolution and PC ownership: evaluates the branch condition from comparator flags,
// computes the target, and drives redirect/flush to fetch/decode; freezes on a misaligned target.
module branch_pc_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 32'd2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic [2:0]  br_funct3,
   input  logic [31:0] br_pc,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        BrEq,
   input  logic        BrLT,
   output logic        BrUn,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        redirect,
   output logic        flush,
   output logic        misalign_exc,
   output logic [15:0] taken_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 32'd1);
   localparam logic       SINGLE_FLUSH = (FLUSH_CYCLES == 32'd1);

   state_t      state_r, state_nxt_s;
   logic [31:0] pc_r, pc_nxt_s;
   logic        redirect_r, redirect_nxt_s;
   logic        flush_r, flush_nxt_s;
   logic        misalign_r, misalign_nxt_s;
   logic [15:0] taken_count_r, taken_count_nxt_s;
   logic [2:0]  fcnt_r, fcnt_nxt_s;

   logic        cond_s;
   logic        taken_s;
   logic        misaligned_s;
   logic [31:0] target_s;
   logic [31:0] jalr_sum_s;

   assign BrUn         = br_funct3[1];
   assign pc_plus4     = pc_r + 32'd4;
   assign pc           = pc_r;
   assign redirect     = redirect_r;
   assign flush        = flush_r;
   assign misalign_exc = misalign_r;
   assign taken_count  = taken_count_r;

   assign jalr_sum_s   = rs1_data + imm;
   assign taken_s      = br_valid & (is_jal | is_jalr | (is_branch & cond_s));
   assign misaligned_s = taken_s & target_s[1];

   // Branch condition from comparator flags; reserved funct3 encodings never take
   always_comb begin
      cond_s = 1'b0;
      case (br_funct3)
         3'b000:         cond_s = BrEq;
         3'b001:         cond_s = ~BrEq;
         3'b100, 3'b110: cond_s = BrLT;
         3'b101, 3'b111: cond_s = ~BrLT;
         default:        cond_s = 1'b0;
      endcase
   end

   // Target select with jal > jalr > branch priority when class bits overlap
   always_comb begin
      target_s = br_pc + imm;
      if (is_jal) begin
         target_s = br_pc + imm;
      end else if (is_jalr) begin
         target_s = {jalr_sum_s[31:1], 1'b0};
      end else begin
         target_s = br_pc + imm;
      end
   end

   // Next-state and next-output logic for the RUN/FLUSH/HALT controller
   always_comb begin
      state_nxt_s       = state_r;
      pc_nxt_s          = pc_r;
      redirect_nxt_s    = 1'b0;
      flush_nxt_s       = flush_r;
      misalign_nxt_s    = misalign_r;
      taken_count_nxt_s = taken_count_r;
      fcnt_nxt_s        = fcnt_r;
      case (state_r)
         RUN: begin
            if (stall) begin
               pc_nxt_s = pc_r;
            end else if (misaligned_s) begin
               pc_nxt_s       = br_pc;
               misalign_nxt_s = 1'b1;
               flush_nxt_s    = 1'b1;
               state_nxt_s    = HALT;
            end else if (taken_s) begin
               pc_nxt_s          = target_s;
               redirect_nxt_s    = 1'b1;
               flush_nxt_s       = 1'b1;
               fcnt_nxt_s        = FLUSH_INIT;
               taken_count_nxt_s = (taken_count_r == 16'hFFFF) ? taken_count_r
                                                               : taken_count_r + 16'd1;
               // a single-cycle flush needs no FLUSH state, so back-to-back redirects stay possible
               state_nxt_s       = SINGLE_FLUSH ? RUN : FLUSH;
            end else begin
               pc_nxt_s    = pc_r + 32'd4;
               flush_nxt_s = 1'b0;
            end
         end
         FLUSH: begin
            if (stall) begin
               pc_nxt_s = pc_r;
            end else if (fcnt_r == 3'd0) begin
               pc_nxt_s    = pc_r + 32'd4;
               flush_nxt_s = 1'b0;
               state_nxt_s = RUN;
            end else begin
               pc_nxt_s   = pc_r + 32'd4;
               fcnt_nxt_s = fcnt_r - 3'd1;
            end
         end
         HALT: begin
            pc_nxt_s    = pc_r;
            flush_nxt_s = 1'b1;
         end
         default: begin
            state_nxt_s = RUN;
            flush_nxt_s = 1'b0;
         end
      endcase
   end

   // Architectural state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= RUN;
         pc_r          <= RESET_PC;
         redirect_r    <= 1'b0;
         flush_r       <= 1'b0;
         misalign_r    <= 1'b0;
         taken_count_r <= 16'd0;
         fcnt_r        <= 3'd0;
      end else begin
         state_r       <= state_nxt_s;
         pc_r          <= pc_nxt_s;
         redirect_r    <= redirect_nxt_s;
         flush_r       <= flush_nxt_s;
         misalign_r    <= misalign_nxt_s;
         taken_count_r <= taken_count_nxt_s;
         fcnt_r        <= fcnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench: unit A uses default parameters; unit B uses FLUSH_CYCLES=1 and a
// non-zero reset PC so the taken-count saturation fits in a short run.
module tb_branch_pc_unit;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
      logic        redirect;
      logic        flush;
      logic        mis;
      logic [15:0] cnt;
      logic        brun;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t mon_e;

   logic        rst_a, a_stall, a_valid, a_br, a_jal, a_jalr, a_eq, a_lt;
   logic [2:0]  a_f3;
   logic [31:0] a_brpc, a_imm, a_rs1;
   logic        a_brun, a_redirect, a_flush, a_mis;
   logic [31:0] a_pc, a_pc4;
   logic [15:0] a_cnt;

   logic        rst_b, b_stall, b_valid, b_br, b_jal, b_jalr, b_eq, b_lt;
   logic [2:0]  b_f3;
   logic [31:0] b_brpc, b_imm, b_rs1;
   logic        b_brun, b_redirect, b_flush, b_mis;
   logic [31:0] b_pc, b_pc4;
   logic [15:0] b_cnt;

   branch_pc_unit dut_a (
      .clk(clk), .rst_n(rst_a), .stall(a_stall), .br_valid(a_valid),
      .is_branch(a_br), .is_jal(a_jal), .is_jalr(a_jalr), .br_funct3(a_f3),
      .br_pc(a_brpc), .imm(a_imm), .rs1_data(a_rs1), .BrEq(a_eq), .BrLT(a_lt),
      .BrUn(a_brun), .pc(a_pc), .pc_plus4(a_pc4), .redirect(a_redirect),
      .flush(a_flush), .misalign_exc(a_mis), .taken_count(a_cnt)
   );

   branch_pc_unit #(.RESET_PC(32'h0000_1000), .FLUSH_CYCLES(32'd1)) dut_b (
      .clk(clk), .rst_n(rst_b), .stall(b_stall), .br_valid(b_valid),
      .is_branch(b_br), .is_jal(b_jal), .is_jalr(b_jalr), .br_funct3(b_f3),
      .br_pc(b_brpc), .imm(b_imm), .rs1_data(b_rs1), .BrEq(b_eq), .BrLT(b_lt),
      .BrUn(b_brun), .pc(b_pc), .pc_plus4(b_pc4), .redirect(b_redirect),
      .flush(b_flush), .misalign_exc(b_mis), .taken_count(b_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input string fld, input int c,
                      input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s cyc=%0d actual=%h required=%h", tag, fld, c, act, req);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic r, input logic f,
                      input logic m, input logic [15:0] c, input logic brun);
      if (e.cyc != cyc) begin
         chk(tag, "stale_entry", cyc, 32'(e.cyc), 32'(cyc));
      end else begin
         chk(tag, "pc", e.cyc, pc, e.pc);
         chk(tag, "pc_plus4", e.cyc, pc4, e.pc + 32'd4);
         chk(tag, "redirect", e.cyc, 32'(r), 32'(e.redirect));
         chk(tag, "flush", e.cyc, 32'(f), 32'(e.flush));
         chk(tag, "misalign_exc", e.cyc, 32'(m), 32'(e.mis));
         chk(tag, "taken_count", e.cyc, 32'(c), 32'(e.cnt));
         chk(tag, "BrUn", e.cyc, 32'(brun), 32'(e.brun));
      end
   endtask

   // Monitor: pops every expectation due at this edge, sampled 1 time unit after it
   always @(posedge clk) begin
      #1;
      while (qa.size() > 0 && qa[0].cyc <= cyc) begin
         mon_e = qa.pop_front();
         cmp("A", mon_e, a_pc, a_pc4, a_redirect, a_flush, a_mis, a_cnt, a_brun);
      end
      while (qb.size() > 0 && qb[0].cyc <= cyc) begin
         mon_e = qb.pop_front();
         cmp("B", mon_e, b_pc, b_pc4, b_redirect, b_flush, b_mis, b_cnt, b_brun);
      end
   end

   task automatic set_a(input logic v, input logic jal, input logic jalr, input logic br,
                        input logic [2:0] f3, input logic [31:0] brpc, input logic [31:0] im,
                        input logic [31:0] rs1, input logic eq, input logic lt, input logic st);
      a_valid = v; a_jal = jal; a_jalr = jalr; a_br = br; a_f3 = f3;
      a_brpc = brpc; a_imm = im; a_rs1 = rs1; a_eq = eq; a_lt = lt; a_stall = st;
   endtask

   task automatic set_b(input logic v, input logic jal, input logic [31:0] brpc,
                        input logic [31:0] im, input logic st);
      b_valid = v; b_jal = jal; b_jalr = 1'b0; b_br = 1'b0; b_f3 = 3'd0;
      b_brpc = brpc; b_imm = im; b_rs1 = 32'd0; b_eq = 1'b0; b_lt = 1'b0; b_stall = st;
   endtask

   // Expected state after the coming rising edge, then advance to the next falling edge
   task automatic push_a(input logic [31:0] pc, input logic r, input logic f, input logic m,
                         input logic [15:0] c, input logic brun);
      exp_t e;
      e.cyc = cyc + 1; e.pc = pc; e.redirect = r; e.flush = f; e.mis = m; e.cnt = c; e.brun = brun;
      qa.push_back(e);
      @(negedge clk);
   endtask

   task automatic push_b(input logic [31:0] pc, input logic r, input logic f, input logic m,
                         input logic [15:0] c, input logic brun);
      exp_t e;
      e.cyc = cyc + 1; e.pc = pc; e.redirect = r; e.flush = f; e.mis = m; e.cnt = c; e.brun = brun;
      qb.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      set_a(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      set_b(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      fork
         begin : thread_a
            push_a(32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            rst_a = 1'b1;
            push_a(32'h4, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            push_a(32'h8, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            push_a(32'hC, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            push_a(32'h10, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            // BLT taken
            set_a(1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 32'h100, 32'h40, 32'd0, 1'b0, 1'b1, 1'b0);
            push_a(32'h140, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
            // a taken JAL while flushing must be ignored
            set_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h500, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            push_a(32'h144, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0);
            set_a(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            push_a(32'h148, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
            // BGEU with BrLT=1: not taken, unsigned select
            set_a(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 32'h148, 32'h40, 32'd0, 1'b0, 1'b1, 1'b0);
            push_a(32'h14C, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
            // reserved funct3 010 never takes
            set_a(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h14C, 32'h40, 32'd0, 1'b1, 1'b1, 1'b0);
            push_a(32'h150, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
            // JALR clears bit 0
            set_a(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h150, 32'd0, 32'h2001, 1'b0, 1'b0, 1'b0);
            push_a(32'h2000, 1'b1, 1'b1, 1'b0, 16'd2, 1'b0);
            set_a(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            push_a(32'h2004, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
            push_a(32'h2008, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0);
            // taken JAL held off by stall for 3 cycles
            set_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h2008, 32'h100, 32'd0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) push_a(32'h2008, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0);
            a_stall = 1'b0;
            push_a(32'h2108, 1'b1, 1'b1, 1'b0, 16'd3, 1'b0);
            // stall during FLUSH stretches flush by 2 cycles
            set_a(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            push_a(32'h2108, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
            push_a(32'h2108, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
            a_stall = 1'b0;
            push_a(32'h210C, 1'b0, 1'b1, 1'b0, 16'd3, 1'b0);
            push_a(32'h2110, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0);
            // jal beats jalr when both are set
            set_a(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h300, 32'h10, 32'h9000, 1'b0, 1'b0, 1'b0);
            push_a(32'h310, 1'b1, 1'b1, 1'b0, 16'd4, 1'b0);
            set_a(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            push_a(32'h314, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0);
            push_a(32'h318, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0);
            // misaligned JALR target 0x2002 halts with pc = br_pc
            set_a(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h318, 32'd0, 32'h2003, 1'b0, 1'b0, 1'b0);
            push_a(32'h318, 1'b0, 1'b1, 1'b1, 16'd4, 1'b0);
            for (int i = 0; i < 10; i++) begin
               set_a(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h40, 32'h40, 32'd0, 1'b0, 1'b0, 1'(i % 2));
               push_a(32'h318, 1'b0, 1'b1, 1'b1, 16'd4, 1'b0);
            end
            set_a(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            rst_a = 1'b0;
            push_a(32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            rst_a = 1'b1;
            push_a(32'h4, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
         end
         begin : thread_b
            push_b(32'h1000, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            rst_b = 1'b1;
            push_b(32'h1004, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
            // back-to-back taken JALs to 0x0, allowed every cycle with a 1-cycle flush
            set_b(1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
            for (int i = 1; i <= 65534; i++) begin
               if (i == 1) push_b(32'h0, 1'b1, 1'b1, 1'b0, 16'd1, 1'b0);
               else if (i == 65534) push_b(32'h0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0);
               else @(negedge clk);
            end
            for (int i = 0; i < 3; i++) push_b(32'h0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0);
            set_b(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFC, 1'b0);
            push_b(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0);
            set_b(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            push_b(32'h0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0);
         end
      join
      repeat (2) @(negedge clk);
      chk("END", "pending_entries", cyc, 32'(qa.size() + qb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
